// File: rtl/smpl_dmem_responder_if.sv
// Core data-port bundle between the smpl core (master) and the data-memory responder (slave).
interface smpl_dmem_responder_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] datao;
    logic              renbl;
    logic              wenbl;
    logic [DATA_W-1:0] datai;
    logic              dvalid;
    logic              derr;
    logic              busy;

    modport master (
        output daddr,
        output datao,
        output renbl,
        output wenbl,
        input  datai,
        input  dvalid,
        input  derr,
        input  busy
    );

    modport slave (
        input  daddr,
        input  datao,
        input  renbl,
        input  wenbl,
        output datai,
        output dvalid,
        output derr,
        output busy
    );
endinterface

// File: rtl/smpl_dmem_responder.sv
// Data-memory responder: registered one-cycle reads, zero-fill sweep after every reset,
// out-of-range accesses answered with derr instead of touching the array.
module smpl_dmem_responder #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    smpl_dmem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_datai;
    logic               r_dvalid;
    logic               r_derr;
    logic               r_busy;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_in_range;
    logic               w_sweep_done;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_mem_we;
    logic [IDX_W-1:0]   w_mem_idx;
    logic [DATA_W-1:0]  w_mem_wdata;

    assign w_in_range   = ({1'b0, bus.daddr} < DEPTH_A);
    assign w_sweep_done = (r_cnt == LAST_IDX);
    assign w_req_idx    = bus.daddr[IDX_W-1:0];

    // Single write port shared by the zero-fill sweep and in-range core writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_req_idx;
        w_mem_wdata = {DATA_W{1'b0}};
        if (r_state == ST_INIT) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_cnt[IDX_W-1:0];
            w_mem_wdata = {DATA_W{1'b0}};
        end else if (bus.wenbl && w_in_range) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = w_req_idx;
            w_mem_wdata = bus.datao;
        end else begin
            w_mem_we    = 1'b0;
        end
    end

    // Storage array; deliberately unreset, the sweep clears it instead.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // INIT/RUN controller with registered response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_INIT;
            r_cnt    <= {CNT_W{1'b0}};
            r_datai  <= {DATA_W{1'b0}};
            r_dvalid <= 1'b0;
            r_derr   <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_dvalid <= 1'b0;
                    r_derr   <= 1'b0;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (w_sweep_done) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_INIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                    if (w_in_range) begin
                        r_derr <= 1'b0;
                        if (bus.renbl) begin
                            r_dvalid <= 1'b1;
                            // Read-with-write forwards the new data, not the old contents.
                            r_datai  <= bus.wenbl ? bus.datao : r_mem[w_req_idx];
                        end else begin
                            r_dvalid <= 1'b0;
                        end
                    end else if (bus.renbl) begin
                        r_datai  <= {DATA_W{1'b0}};
                        r_dvalid <= 1'b1;
                        r_derr   <= 1'b1;
                    end else if (bus.wenbl) begin
                        r_dvalid <= 1'b0;
                        r_derr   <= 1'b1;
                    end else begin
                        r_dvalid <= 1'b0;
                        r_derr   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_INIT;
                    r_cnt    <= {CNT_W{1'b0}};
                    r_dvalid <= 1'b0;
                    r_derr   <= 1'b0;
                    r_busy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.datai  = r_datai;
    assign bus.dvalid = r_dvalid;
    assign bus.derr   = r_derr;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_smpl_dmem_responder.sv
// Directed bench for smpl_dmem_responder: init sweep timing, read/write, forwarding,
// out-of-range handling, busy-ignore and reset in the middle of a read.
module tb_smpl_dmem_responder;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 128;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   edges;
    int   resp;

    smpl_dmem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    smpl_dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.renbl = 1'b0;
        bus.wenbl = 1'b0;
        bus.daddr = '0;
        bus.datao = '0;
    endtask

    // Drive one request across a single rising edge, then sample 1 ns after it.
    task automatic cyc(input logic re, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
        bus.renbl = re;
        bus.wenbl = we;
        bus.daddr = a;
        bus.datao = d;
        @(posedge clock);
        #1;
        idle();
    endtask

    // Count edges until busy drops (bounded), tallying any response seen meanwhile.
    task automatic wait_busy(output int n, output int r);
        n = 0;
        r = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.dvalid !== 1'b0 || bus.derr !== 1'b0) r++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy",   {31'd0, bus.busy},   32'd1);
        chk("rst_dvalid", {31'd0, bus.dvalid}, 32'd0);
        chk("rst_derr",   {31'd0, bus.derr},   32'd0);
        chk("rst_datai",  {16'd0, bus.datai},  32'd0);

        // First sweep with a write to 3 held on the bus the whole time.
        reset = 1'b1;
        bus.wenbl = 1'b1;
        bus.daddr = 13'd3;
        bus.datao = 16'h7777;
        wait_busy(edges, resp);
        idle();
        chk("init1_edges", edges, 32'd128);
        chk("init1_noresp", resp, 32'd0);
        cyc(1'b1, 1'b0, 13'd3, 16'h0);
        chk("busy_ign_data",  {16'd0, bus.datai},  32'h0000);
        chk("busy_ign_valid", {31'd0, bus.dvalid}, 32'd1);

        // Fill with garbage so the second sweep has something to clear.
        cyc(1'b0, 1'b1, 13'd0,   16'hDEAD);
        cyc(1'b0, 1'b1, 13'd64,  16'hDEAD);
        cyc(1'b0, 1'b1, 13'd127, 16'hDEAD);
        cyc(1'b0, 1'b1, 13'd72,  16'hDEAD);
        cyc(1'b1, 1'b0, 13'd127, 16'h0);
        chk("garbage_rd", {16'd0, bus.datai}, 32'hDEAD);

        reset = 1'b0;
        #1;
        chk("rst2_busy",   {31'd0, bus.busy},   32'd1);
        chk("rst2_dvalid", {31'd0, bus.dvalid}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        wait_busy(edges, resp);
        chk("init2_edges", edges, 32'd128);
        cyc(1'b1, 1'b0, 13'd0, 16'h0);
        chk("sweep_rd0",  {16'd0, bus.datai},  32'h0000);
        chk("sweep_v0",   {31'd0, bus.dvalid}, 32'd1);
        cyc(1'b1, 1'b0, 13'd64, 16'h0);
        chk("sweep_rd64", {16'd0, bus.datai},  32'h0000);
        chk("sweep_v64",  {31'd0, bus.dvalid}, 32'd1);
        cyc(1'b1, 1'b0, 13'd127, 16'h0);
        chk("sweep_rd127", {16'd0, bus.datai}, 32'h0000);
        chk("sweep_v127",  {31'd0, bus.dvalid}, 32'd1);

        // Write/read back-to-back.
        cyc(1'b0, 1'b1, 13'd5, 16'hBEEF);
        chk("wr5_novalid", {31'd0, bus.dvalid}, 32'd0);
        cyc(1'b0, 1'b1, 13'd6, 16'h1234);
        cyc(1'b1, 1'b0, 13'd5, 16'h0);
        chk("rd5_data",  {16'd0, bus.datai},  32'hBEEF);
        chk("rd5_valid", {31'd0, bus.dvalid}, 32'd1);
        cyc(1'b1, 1'b0, 13'd6, 16'h0);
        chk("rd6_data",  {16'd0, bus.datai},  32'h1234);
        chk("rd6_valid", {31'd0, bus.dvalid}, 32'd1);
        cyc(1'b0, 1'b0, 13'd0, 16'h0);
        chk("idle_valid", {31'd0, bus.dvalid}, 32'd0);
        chk("idle_hold",  {16'd0, bus.datai},  32'h1234);
        cyc(1'b0, 1'b1, 13'd20, 16'h4242);
        cyc(1'b1, 1'b0, 13'd20, 16'h0);
        chk("raw_next", {16'd0, bus.datai}, 32'h4242);

        // Simultaneous read+write forwards write data.
        cyc(1'b0, 1'b1, 13'd9, 16'h0001);
        cyc(1'b1, 1'b1, 13'd9, 16'hA5A5);
        chk("rw_fwd",   {16'd0, bus.datai},  32'hA5A5);
        chk("rw_valid", {31'd0, bus.dvalid}, 32'd1);
        cyc(1'b1, 1'b0, 13'd9, 16'h0);
        chk("rw_later", {16'd0, bus.datai}, 32'hA5A5);

        // Out-of-range accesses.
        cyc(1'b0, 1'b1, 13'd200, 16'hFFFF);
        chk("oor_wr_derr",   {31'd0, bus.derr},   32'd1);
        chk("oor_wr_dvalid", {31'd0, bus.dvalid}, 32'd0);
        cyc(1'b0, 1'b0, 13'd0, 16'h0);
        chk("oor_derr_pulse", {31'd0, bus.derr}, 32'd0);
        cyc(1'b1, 1'b0, 13'd200, 16'h0);
        chk("oor_rd_data",  {16'd0, bus.datai},  32'h0000);
        chk("oor_rd_valid", {31'd0, bus.dvalid}, 32'd1);
        chk("oor_rd_derr",  {31'd0, bus.derr},   32'd1);
        cyc(1'b1, 1'b0, 13'd72, 16'h0);
        chk("alias72_data", {16'd0, bus.datai}, 32'h0000);
        chk("alias72_derr", {31'd0, bus.derr},  32'd0);

        // Reset asserted while a read is on the bus.
        cyc(1'b0, 1'b1, 13'd10, 16'h5555);
        cyc(1'b1, 1'b0, 13'd10, 16'h0);
        chk("pre_rst_rd10", {16'd0, bus.datai}, 32'h5555);
        bus.renbl = 1'b1;
        bus.daddr = 13'd10;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_dvalid", {31'd0, bus.dvalid}, 32'd0);
        chk("midrst_busy",   {31'd0, bus.busy},   32'd1);
        chk("midrst_datai",  {16'd0, bus.datai},  32'h0000);
        @(posedge clock);
        #1;
        chk("midrst_dvalid2", {31'd0, bus.dvalid}, 32'd0);
        idle();
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_busy(edges, resp);
        chk("init3_edges", edges, 32'd128);
        cyc(1'b1, 1'b0, 13'd10, 16'h0);
        chk("post_rst_rd10", {16'd0, bus.datai},  32'h0000);
        chk("post_rst_v10",  {31'd0, bus.dvalid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
